// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage: valid/ready handshake on both sides with a two-entry skid buffer,
// synchronous flush, fault-to-NOP substitution and a saturating stall-cycle counter.
module if_id_skid_stage #(
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32,
    parameter bit FAULT_NOP = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_pc4,
    input  logic              in_fault,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc4,
    output logic              out_fault,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic              fault;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             acc;
    logic             deq;

    // in_ready is decoded from the state register alone, so out_ready never reaches it.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_inst  = main_q.inst;
    assign out_pc    = main_q.pc;
    assign out_pc4   = main_q.pc4;
    assign out_fault = main_q.fault;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        acc = in_valid & in_ready & ~flush;
        deq = out_valid & out_ready;

        in_entry.inst  = (FAULT_NOP && in_fault) ? '0 : in_inst;
        in_entry.pc    = in_pc;
        in_entry.pc4   = in_pc4;
        in_entry.fault = in_fault;

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        main_d  = in_entry;
                    end
                end
                FULL: begin
                    if (acc && deq) begin
                        main_d = in_entry;
                    end else if (acc) begin
                        state_d = SKID;
                        skid_d  = in_entry;
                    end else if (deq) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (deq) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_if_id_skid_stage;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [INST_W-1:0] in_inst = '0;
    logic [ADDR_W-1:0] in_pc = '0;
    logic [ADDR_W-1:0] in_pc4 = '0;
    logic              in_fault = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc4;
    logic              out_fault;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    if_id_skid_stage #(
        .INST_W   (INST_W),
        .ADDR_W   (ADDR_W),
        .FAULT_NOP(1'b1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .in_pc4   (in_pc4),
        .in_fault (in_fault),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .out_pc4  (out_pc4),
        .out_fault(out_fault),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an ordered FIFO of at most two entries and a stall tally.
    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic              fault;
    } entry_t;

    entry_t m_q[$];
    int     m_stalls = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_stalls = 0;
        end else begin
            automatic bit m_valid = (m_q.size() > 0);
            automatic bit m_rdy   = (m_q.size() < 2);
            automatic entry_t e;
            if (m_valid && !out_ready && m_stalls < CNT_MAX) m_stalls++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_valid && out_ready) void'(m_q.pop_front());
                if (in_valid && m_rdy) begin
                    e.inst  = in_fault ? '0 : in_inst;
                    e.pc    = in_pc;
                    e.pc4   = in_pc4;
                    e.fault = in_fault;
                    m_q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        check("cmp_in_ready", 64'(in_ready), 64'(m_q.size() < 2));
        check("cmp_occupancy", 64'(occupancy), 64'(m_q.size()));
        check("cmp_stall_cnt", 64'(stall_cnt), 64'(m_stalls));
        if (m_q.size() > 0) begin
            check("cmp_out_inst", 64'(out_inst), 64'(m_q[0].inst));
            check("cmp_out_pc", 64'(out_pc), 64'(m_q[0].pc));
            check("cmp_out_pc4", 64'(out_pc4), 64'(m_q[0].pc4));
            check("cmp_out_fault", 64'(out_fault), 64'(m_q[0].fault));
        end
    end

    task automatic drive(input logic v, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                         input logic fault, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_pc4    = pc + 32'd4;
        in_inst   = inst;
        in_fault  = fault;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        rst = 1'b0;

        // Stream A,B,C with ID always ready
        drive(1, 32'h100, 32'hA, 0, 1, 0);
        check("s1_a_valid", 64'(out_valid), 64'd1);
        check("s1_a_pc", 64'(out_pc), 64'h100);
        drive(1, 32'h104, 32'hB, 0, 1, 0);
        check("s1_b_pc", 64'(out_pc), 64'h104);
        check("s1_b_occ", 64'(occupancy), 64'd1);
        drive(1, 32'h108, 32'hC, 0, 1, 0);
        check("s1_c_pc", 64'(out_pc), 64'h108);
        drive(0, 32'h0, 32'h0, 0, 1, 0);
        check("s1_drained", 64'(out_valid), 64'd0);

        // ID stalls while A,B,C are offered
        drive(1, 32'h200, 32'h11, 0, 0, 0);
        drive(1, 32'h204, 32'h22, 0, 0, 0);
        check("s2_in_ready", 64'(in_ready), 64'd0);
        check("s2_occ", 64'(occupancy), 64'd2);
        drive(1, 32'h208, 32'h33, 0, 0, 0);
        check("s2_hold_a", 64'(out_pc), 64'h200);
        check("s2_stalls", 64'(stall_cnt), 64'd2);
        drive(1, 32'h208, 32'h33, 0, 1, 0);
        check("s2_then_b", 64'(out_pc), 64'h204);
        drive(1, 32'h208, 32'h33, 0, 1, 0);
        check("s2_then_c", 64'(out_pc), 64'h208);
        drive(0, 32'h0, 32'h0, 0, 1, 0);
        check("s2_stalls_end", 64'(stall_cnt), 64'd2);

        // Flush from SKID with a simultaneous input
        drive(1, 32'h300, 32'h44, 0, 0, 0);
        drive(1, 32'h304, 32'h55, 0, 0, 0);
        drive(1, 32'h308, 32'h66, 0, 0, 1);
        check("s3_occ", 64'(occupancy), 64'd0);
        check("s3_out_valid", 64'(out_valid), 64'd0);
        check("s3_in_ready", 64'(in_ready), 64'd1);
        check("s3_stalls", 64'(stall_cnt), 64'd4);
        drive(0, 32'h0, 32'h0, 0, 1, 0);
        check("s3_no_ghost", 64'(out_valid), 64'd0);

        // Faulting fetch becomes a NOP
        drive(1, 32'hBFC00010, 32'h8C010004, 1, 1, 0);
        check("s4_inst", 64'(out_inst), 64'd0);
        check("s4_fault", 64'(out_fault), 64'd1);
        check("s4_pc", 64'(out_pc), 64'hBFC00010);
        check("s4_pc4", 64'(out_pc4), 64'hBFC00014);
        drive(0, 32'h0, 32'h0, 0, 1, 0);

        // Asynchronous reset while in SKID
        drive(1, 32'h400, 32'h77, 0, 0, 0);
        drive(1, 32'h404, 32'h88, 0, 0, 0);
        check("s5_pre_occ", 64'(occupancy), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("s5_out_valid", 64'(out_valid), 64'd0);
        check("s5_in_ready", 64'(in_ready), 64'd1);
        check("s5_occ", 64'(occupancy), 64'd0);
        check("s5_out_pc", 64'(out_pc), 64'd0);
        check("s5_stalls", 64'(stall_cnt), 64'd0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        rst = 1'b0;

        // Stall counter saturation
        drive(1, 32'h500, 32'h99, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 32'h0, 32'h0, 0, 0, 0);
            if (i == 14) check("s6_reach_max", 64'(stall_cnt), 64'd15);
        end
        check("s6_saturated", 64'(stall_cnt), 64'd15);
        check("s6_still_a", 64'(out_pc), 64'h500);
        drive(0, 32'h0, 32'h0, 0, 1, 0);
        check("s6_drained", 64'(out_valid), 64'd0);
        check("s6_hold_after", 64'(stall_cnt), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
